// File: rtl/lzs_history_ctrl_if.sv
// Bus bundle between the LZS token parser, the history RAM, the output FIFO
// and lzs_history_ctrl. The controller connects through the slave modport;
// the surrounding logic (parser, RAM, FIFO) uses the master modport.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both 1. cmd_type/cmd_literal/cmd_offset/
// cmd_length must be stable while cmd_valid is 1. cmd_ready may depend
// combinationally on fo_full but never on cmd_valid.
interface lzs_history_ctrl_if #(
  parameter int HIST_AW = 11,
  parameter int LEN_W   = 16
);
  // token parser -> controller
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [7:0]         cmd_literal;
  logic [HIST_AW-1:0] cmd_offset;
  logic [LEN_W-1:0]   cmd_length;

  // controller <-> history RAM (read data returns one cycle after hist_re)
  logic               hist_we;
  logic [HIST_AW-1:0] hist_waddr;
  logic [7:0]         hist_wdata;
  logic               hist_re;
  logic [HIST_AW-1:0] hist_raddr;
  logic [7:0]         hist_rdata;

  // controller -> output FIFO
  logic               fo_full;
  logic               out_valid;
  logic [7:0]         out_data;

  // status
  logic               busy;
  logic               all_end;
  logic               copy_err;

  modport slave (
    input  cmd_valid, cmd_type, cmd_literal, cmd_offset, cmd_length,
    input  hist_rdata, fo_full,
    output cmd_ready,
    output hist_we, hist_waddr, hist_wdata, hist_re, hist_raddr,
    output out_valid, out_data,
    output busy, all_end, copy_err
  );

  modport master (
    output cmd_valid, cmd_type, cmd_literal, cmd_offset, cmd_length,
    output hist_rdata, fo_full,
    input  cmd_ready,
    input  hist_we, hist_waddr, hist_wdata, hist_re, hist_raddr,
    input  out_valid, out_data,
    input  busy, all_end, copy_err
  );
endinterface

// File: rtl/lzs_history_ctrl.sv
// lzs_history_ctrl: sequences the LZS decoder's history RAM.
// Literal commands write one byte; copy commands replay (offset, length)
// bytes from the history window, one byte per cycle, writing each copied
// byte back into the window and streaming it to the output FIFO.
// Optional feature macro: LZS_HIST_CHECK_EN (flags copies that reach
// further back than the number of bytes written since reset).
module lzs_history_ctrl #(
  parameter int HIST_AW = 11,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  lzs_history_ctrl_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_END  = 2'd2
  } state_t;

  localparam logic [1:0]         CMD_LIT  = 2'd0;
  localparam logic [1:0]         CMD_COPY = 2'd1;
  localparam logic [HIST_AW-1:0] AW_ONE   = {{(HIST_AW-1){1'b0}}, 1'b1};
  localparam logic [HIST_AW-1:0] AW_ZERO  = '0;
  localparam logic [LEN_W-1:0]   LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   LEN_ZERO = '0;

  // Control state
  state_t             state_q, state_d;
  logic               all_end_q, all_end_d;

  // Write pointer: address of the next history write
  logic [HIST_AW-1:0] wp_q, wp_d;

  // Copy engine: read pointer and bytes still to be read
  logic [HIST_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;

  // Literal write scheduled for this cycle
  logic               lit_q, lit_d;
  logic [7:0]         lit_data_q, lit_data_d;

  // Copy read issued last cycle; its byte is written/output this cycle
  logic               pend_q, pend_d;

  // Last read hit the address being written in the same cycle, so the RAM
  // returned stale data; the captured write byte is used instead.
  logic               byp_q, byp_d;
  logic [7:0]         byp_data_q, byp_data_d;

  // Combinational helpers
  logic               cmd_ready;
  logic               cmd_fire;
  logic               rd_en;
  logic               wr_en;
  logic [7:0]         ret_data;
  logic [7:0]         wr_data;
  logic [LEN_W-1:0]   len_eff;

  // Datapath: what is written and output this cycle
  always_comb begin
    wr_en    = lit_q | pend_q;
    ret_data = byp_q ? byp_data_q : bus.hist_rdata;
    if (lit_q) begin
      wr_data = lit_data_q;
    end else if (pend_q) begin
      wr_data = ret_data;
    end else begin
      wr_data = 8'h00;
    end
  end

  // Handshake and read issue; reads and accepts both stop while the FIFO is near full
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) & ~bus.fo_full & ~all_end_q & ~rst;
    cmd_fire  = bus.cmd_valid & cmd_ready;
    rd_en     = (state_q == ST_COPY) & ~bus.fo_full & (rem_q != LEN_ZERO);
    len_eff   = (bus.cmd_length == LEN_ZERO) ? LEN_ONE : bus.cmd_length;
  end

  // Next-state and register updates for the FSM and copy engine
  always_comb begin
    state_d    = state_q;
    all_end_d  = all_end_q;
    wp_d       = wr_en ? (wp_q + AW_ONE) : wp_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    lit_d      = 1'b0;
    lit_data_d = lit_data_q;
    pend_d     = rd_en;
    byp_d      = rd_en & wr_en & (rd_ptr_q == wp_q);
    byp_data_d = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_type)
            CMD_LIT: begin
              lit_d      = 1'b1;
              lit_data_d = bus.cmd_literal;
            end
            CMD_COPY: begin
              // Offset 0 wraps to the full window (wp - 0 == oldest byte).
              // wp_d already accounts for a copy byte still being written.
              rd_ptr_d = wp_d - bus.cmd_offset;
              rem_d    = len_eff;
              state_d  = ST_COPY;
            end
            default: begin
              all_end_d = 1'b1;
              state_d   = ST_END;
            end
          endcase
        end
      end
      ST_COPY: begin
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + AW_ONE;
          rem_d    = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = ST_IDLE;
          end
        end else if (rem_q == LEN_ZERO) begin
          state_d = ST_IDLE;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pointer registers; reset discards any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      all_end_q  <= 1'b0;
      wp_q       <= AW_ZERO;
      rd_ptr_q   <= AW_ZERO;
      rem_q      <= LEN_ZERO;
      lit_q      <= 1'b0;
      lit_data_q <= 8'h00;
      pend_q     <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      all_end_q  <= all_end_d;
      wp_q       <= wp_d;
      rd_ptr_q   <= rd_ptr_d;
      rem_q      <= rem_d;
      lit_q      <= lit_d;
      lit_data_q <= lit_data_d;
      pend_q     <= pend_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

`ifdef LZS_HIST_CHECK_EN
  localparam logic [HIST_AW:0] WIN      = {1'b1, {HIST_AW{1'b0}}};
  localparam logic [HIST_AW:0] CNT_ONE  = {{HIST_AW{1'b0}}, 1'b1};
  localparam logic [HIST_AW:0] CNT_ZERO = '0;

  logic [HIST_AW:0] wcnt_q, wcnt_d;
  logic [HIST_AW:0] off_eff;
  logic             copy_err_q, copy_err_d;

  // Saturating count of bytes written; a copy reaching past it is flagged
  always_comb begin
    wcnt_d = wcnt_q;
    if (wr_en && (wcnt_q != WIN)) begin
      wcnt_d = wcnt_q + CNT_ONE;
    end
    off_eff    = (bus.cmd_offset == AW_ZERO) ? WIN : {1'b0, bus.cmd_offset};
    copy_err_d = copy_err_q;
    if (cmd_fire && (bus.cmd_type == CMD_COPY) && (off_eff > wcnt_d)) begin
      copy_err_d = 1'b1;
    end
  end

  // History-check registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q     <= CNT_ZERO;
      copy_err_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      copy_err_q <= copy_err_d;
    end
  end

  assign bus.copy_err = copy_err_q;
`else
  assign bus.copy_err = 1'b0;
`endif

  // Outputs
  assign bus.cmd_ready  = cmd_ready;
  assign bus.hist_we    = wr_en;
  assign bus.hist_waddr = wp_q;
  assign bus.hist_wdata = wr_data;
  assign bus.hist_re    = rd_en;
  assign bus.hist_raddr = rd_ptr_q;
  assign bus.out_valid  = wr_en;
  assign bus.out_data   = wr_data;
  assign bus.busy       = (state_q == ST_COPY) | pend_q;
  assign bus.all_end    = all_end_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lzs_history_ctrl.sv
// Testbench for lzs_history_ctrl: directed test-plan steps plus a random
// command phase, checked against a byte-level history model.
module tb_lzs_history_ctrl;
  localparam int AW = 11;
  localparam int LW = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  lzs_history_ctrl_if #(.HIST_AW(AW), .LEN_W(LW)) bus ();

  lzs_history_ctrl #(.HIST_AW(AW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters, model, scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic       rand_bp = 1'b0;
  logic [7:0] mem [2048];
  logic [7:0] hm  [2048];
  logic [10:0] mwp = '0;
  logic [18:0] exp_q [$];
  logic [10:0] rexp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: decoded stream built byte by byte from the window
  function automatic void model_accept(input logic [1:0] t, input logic [7:0] lit,
                                       input logic [10:0] off, input logic [15:0] len);
    int oe, le;
    logic [10:0] a;
    logic [7:0]  b;
    if (t == 2'd0) begin
      hm[mwp] = lit;
      exp_q.push_back({mwp, lit});
      mwp++;
    end else if (t == 2'd1) begin
      oe = (off == 0) ? 2048 : int'(off);
      le = (len == 0) ? 1 : int'(len);
      for (int i = 0; i < le; i++) begin
        a = mwp - 11'(oe);
        b = hm[a];
        rexp_q.push_back(a);
        hm[mwp] = b;
        exp_q.push_back({mwp, b});
        mwp++;
      end
    end
  endfunction

  // History RAM: read returns old contents on a same-address write
  always @(posedge clk) begin
    if (bus.hist_re) bus.hist_rdata <= mem[bus.hist_raddr];
    if (bus.hist_we) mem[bus.hist_waddr] <= bus.hist_wdata;
  end

  // Random FIFO backpressure
  always @(negedge clk) begin
    if (rand_bp) bus.fo_full = ($urandom_range(0, 3) == 0);
  end

  // Monitor: every written/output byte and every read against the model
  always @(negedge clk) begin
    logic [18:0] e;
    logic [10:0] r;
    #2;
    if (!rst) begin
      check("we_eq_valid", bus.hist_we, bus.out_valid);
      if (bus.out_valid === 1'b1) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e[7:0]);
          check("hist_wdata", bus.hist_wdata, e[7:0]);
          check("hist_waddr", bus.hist_waddr, e[18:8]);
        end
      end
      if (bus.hist_re === 1'b1) begin
        check("read_expected", rexp_q.size() != 0, 1);
        if (rexp_q.size() != 0) begin
          r = rexp_q.pop_front();
          check("hist_raddr", bus.hist_raddr, r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] t, input logic [7:0] lit,
                      input logic [10:0] off, input logic [15:0] len);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_type    = t;
    bus.cmd_literal = lit;
    bus.cmd_offset  = off;
    bus.cmd_length  = len;
    while (!acc && n < 200) begin
      #1;
      acc = bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accepted", acc, 1);
    if (acc) model_accept(t, lit, off, len);
  endtask

  task automatic drain();
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < 400) begin
      @(negedge clk);
      #3;
      pending = (exp_q.size() != 0) || (rexp_q.size() != 0) || (bus.busy !== 1'b0);
      n++;
    end
    check("drain_done", pending, 0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stall_bytes;
    logic [1:0] st0;
    logic [1:0] rt;
    logic [10:0] ro;
    logic [15:0] rl;

    for (int i = 0; i < 2048; i++) begin mem[i] = 8'h00; hm[i] = 8'h00; end
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_literal = 8'h00;
    bus.cmd_offset = '0; bus.cmd_length = '0; bus.fo_full = 1'b0; bus.hist_rdata = 8'h00;

    // Reset state
    @(negedge clk); #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hist_we", bus.hist_we, 0);
    check("rst_hist_re", bus.hist_re, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_all_end", bus.all_end, 0);
    check("rst_copy_err", bus.copy_err, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_waddr", bus.hist_waddr, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);

    // Literals ABC, then copy offset 3 length 6 with latency checks
    send(2'd0, 8'h41, 0, 0);
    send(2'd0, 8'h42, 0, 0);
    send(2'd0, 8'h43, 0, 0);
    send(2'd1, 8'h00, 11'd3, 16'd6);
    #3;
    check("copy_t1_no_out", bus.out_valid, 0);
    check("copy_t1_busy", bus.busy, 1);
    check("copy_t1_ready", bus.cmd_ready, 0);
    check("copy_no_err", bus.copy_err, 0);
    @(negedge clk); #3;
    check("copy_t2_out", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #3 check("copy_t6_ready", bus.cmd_ready, 0);
    @(negedge clk); #3;
    check("copy_t7_ready", bus.cmd_ready, 1);
    check("copy_t7_busy", bus.busy, 1);
    check("copy_t7_out", bus.out_valid, 1);
    @(negedge clk); #3;
    check("copy_t8_idle", bus.busy, 0);
    drain();

    // Overlapping copy: literal 0x78 then offset 1 length 5
    send(2'd0, 8'h78, 0, 0);
    send(2'd1, 8'h00, 11'd1, 16'd5);
    drain();
    for (int i = 9; i <= 14; i++) check("overlap_ram", mem[i], 8'h78);

    // Fill to wp=2046, then copy across the wrap point
    for (int i = 0; i < 2031; i++) send(2'd0, 8'($urandom_range(0, 255)), 0, 0);
    send(2'd1, 8'h00, 11'd4, 16'd6);
    drain();

    // Random commands under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rt = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'd1;
      case ($urandom_range(0, 3))
        0: ro = 11'($urandom_range(1, 3));
        1: ro = 11'd0;
        default: ro = 11'($urandom_range(1, 2047));
      endcase
      rl = 16'($urandom_range(0, 12));
      send(rt, 8'($urandom_range(0, 255)), ro, rl);
    end
    drain();
    rand_bp = 1'b0;
    bus.fo_full = 1'b0;
    @(negedge clk);

    // Stall for 3 cycles in the middle of a length-8 copy
    send(2'd1, 8'h00, 11'd8, 16'd8);
    @(negedge clk);
    @(negedge clk);
    bus.fo_full = 1'b1;
    stall_bytes = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      if (bus.out_valid === 1'b1) stall_bytes++;
      check("stall_no_read", bus.hist_re, 0);
      check("stall_no_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.fo_full = 1'b0;
    check("stall_bytes_le1", stall_bytes <= 1, 1);
    drain();

    // Reset pulse mid-copy
    send(2'd1, 8'h00, 11'd5, 16'd10);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rexp_q.delete();
    for (int i = 0; i < 2048; i++) begin mem[i] = 8'h00; hm[i] = 8'h00; end
    mwp = '0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_wp", bus.hist_waddr, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_re", bus.hist_re, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Copy reaching beyond written history
    send(2'd0, 8'h11, 0, 0);
    send(2'd0, 8'h22, 0, 0);
    send(2'd1, 8'h00, 11'd5, 16'd3);
    #1;
`ifdef LZS_HIST_CHECK_EN
    check("copy_err_set", bus.copy_err, 1);
`else
    check("copy_err_tied", bus.copy_err, 0);
`endif
    drain();

    // End command: sticky, and nothing accepted afterwards
    send(2'd2, 8'h00, 0, 0);
    #1;
    check("end_all_end", bus.all_end, 1);
    check("end_ready", bus.cmd_ready, 0);
    st0 = dbg_state;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("end_ready_hold", bus.cmd_ready, 0);
      check("end_sticky", bus.all_end, 1);
      check("end_state_hold", dbg_state, st0);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk); #3;
    check("end_no_bytes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
